predecode_buffer: RTL
=====================

Name: predecode_buffer

Overview:
- N-wide successor to the single-lane fetch pre-decoder. Pre-decodes a WIDTH-lane fetch bundle: branch/jump class, call/return hints and PC-relative targets.
- Stores up to DEPTH pre-decoded bundles in a FIFO between fetch and decode.
- Exposes the first control-flow lane per bundle, so the branch predictor and next-PC logic can redirect without re-decoding.

Parameters:
- WIDTH, 2, instruction lanes per bundle (>=1).
- DEPTH, 4, bundle entries in the FIFO (power of 2, >=2).
- TRUNCATE_CF, 1, if 1, lanes younger than the first unconditional jump (JAL/JALR) are invalidated at enqueue.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  squash all entries (mispredict/exception)
- in_valid  in  1  bundle offered
- in_ready  out  1  buffer can accept a bundle this cycle
- in_lane_valid  in  WIDTH  per-lane valid mask
- in_pc  in  WIDTH x 32  per-lane PC
- in_inst  in  WIDTH x INST  per-lane instruction
- out_valid  out  1  head bundle available
- out_ready  in  1  consumer takes head this cycle
- out_pd  out  WIDTH x PREDECODE_PACKET  head bundle, pre-decoded
- out_cf_found  out  1  head bundle contains a valid control-flow lane
- out_cf_lane  out  $clog2(WIDTH) (min 1)  index of the oldest such lane
- count  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset values:
  - count=0, head=tail=0, in_ready=1, out_valid=0.
  - out_pd all-zero; out_cf_found=0; out_cf_lane=0.
- Per-lane pre-decode is combinational on the input side, and the result is written at enqueue. Each PREDECODE_PACKET holds: valid, pc, inst, cond_branch, jal, jalr, is_call, is_return, target.
  - cond_branch: BEQ/BNE/BLT/BGE/BLTU/BGEU. target = pc + sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}).
  - jal: target = pc + sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}).
  - jalr: target = 0, because it is register-dependent and resolved downstream.
  - is_call: (jal|jalr) and rd in {x1,x5}.
  - is_return: jalr, rs1 in {x1,x5}, rd=x0, and rs1!=rd.
  - A lane with lane_valid=0 gets every flag and target zeroed, with valid=0.
  - All target arithmetic is 32-bit modulo 2^32 (wrap-around, no overflow flag).
- Control-flow lane: the lowest-index valid lane with cond_branch|jal|jalr.
  - cf_found and cf_lane are computed at enqueue and stored with the entry.
  - If TRUNCATE_CF=1 and that lane is jal or jalr, lanes with higher index have valid forced to 0.
  - Conditional branches never truncate.
- Handshake:
  - Enqueue when in_valid & in_ready. Dequeue when out_valid & out_ready.
  - in_ready = (count < DEPTH). There is no same-cycle bypass when full: with a full FIFO and simultaneous dequeue, in_ready stays 0.
  - out_valid = (count != 0). out_pd/out_cf_* always reflect the head entry registered in storage.
  - Minimum latency from enqueue to out_valid is 1 cycle.
  - Simultaneous enqueue and dequeue with 0 < count < DEPTH leaves count unchanged.
  - An enqueue with all lanes invalid is still accepted and occupies an entry.
- Pointers: head and tail are $clog2(DEPTH) bits and wrap modulo DEPTH.
- flush:
  - Next cycle, count=0 and head=tail=0, identical to reset for FIFO state.
  - An enqueue or dequeue in the same cycle as flush is discarded; flush has priority.
  - Storage contents need not be cleared, but outputs must read zero while empty.
- reset mid-operation has priority over flush and the handshakes.
- Assertions in the bench: no enqueue while !in_ready; count never exceeds DEPTH.

Decomposition:
- Shared sys_defs package: PREDECODE_PACKET struct; opcode/funct3 constants for branches, JAL, and JALR reuse the existing RV32_* casez patterns.
- Sub-module predecode_lane: the combinational per-lane decoder (flags and target), instantiated WIDTH times.
- Priority selection, truncation, and the FIFO live in the top.

Test Plan:
1. Reset, then enqueue lane0 = 0x008000EF (jal x1,+8) at pc 0x100, lane1 = 0x00000013 (nop) at pc 0x104, TRUNCATE_CF=1 -> next cycle out_valid=1; lane0 jal=1, is_call=1, target=0x108; cf_found=1, cf_lane=0; lane1 valid=0.
2. Enqueue lane0 = nop at 0x200, lane1 = 0xFE000EE3 (beq x0,x0,-4) at 0x204 -> lane1 cond_branch=1, target=0x200, cf_lane=1, lane0 still valid.
3. lane0 = 0x00008067 (ret) at 0x300 -> jalr=1, is_return=1, is_call=0, target=0; lane1 invalidated.
4. Enqueue DEPTH=4 bundles with out_ready=0 -> count=4 and in_ready=0. Then drive out_ready=1 and in_valid=1 together -> no enqueue that cycle, count=3, and the next enqueue is accepted.
5. JAL with imm=+8 at pc 0xFFFFFFFC -> target=0x00000004 (wrap).
6. count=3, assert flush together with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, out_pd zeroed, in_ready=1.

Source files
------------

// File: rtl/predecode_buffer_pkg.sv
// Shared definitions for the pre-decode buffer: packet layout and RV32 control-flow encodings.
package predecode_buffer_pkg;

  localparam int INST_W = 32;

  typedef struct packed {
    logic              valid;
    logic [31:0]       pc;
    logic [INST_W-1:0] inst;
    logic              cond_branch;
    logic              jal;
    logic              jalr;
    logic              is_call;
    logic              is_return;
    logic [31:0]       target;
  } predecode_packet_t;

  localparam int PD_W = $bits(predecode_packet_t);

  localparam logic [6:0] RV32_OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] RV32_OPC_JAL    = 7'b1101111;
  localparam logic [6:0] RV32_OPC_JALR   = 7'b1100111;

  localparam logic [2:0] RV32_F3_BEQ  = 3'b000;
  localparam logic [2:0] RV32_F3_BNE  = 3'b001;
  localparam logic [2:0] RV32_F3_BLT  = 3'b100;
  localparam logic [2:0] RV32_F3_BGE  = 3'b101;
  localparam logic [2:0] RV32_F3_BLTU = 3'b110;
  localparam logic [2:0] RV32_F3_BGEU = 3'b111;
  localparam logic [2:0] RV32_F3_JALR = 3'b000;

  // x1 (ra) and x5 (t0) are the link registers used for call/return hints
  function automatic logic is_link_reg(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

endpackage

// File: rtl/predecode_buffer_lane.sv
// Combinational pre-decoder for a single fetch lane: control-flow class, call/return hints, target.
module predecode_buffer_lane
  import predecode_buffer_pkg::*;
(
  input  logic              lane_valid,
  input  logic [31:0]       pc,
  input  logic [INST_W-1:0] inst,
  output predecode_packet_t pd
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [31:0] br_imm;
  logic [31:0] jal_imm;
  logic        is_br;
  logic        is_jal;
  logic        is_jalr;

  assign opcode  = inst[6:0];
  assign funct3  = inst[14:12];
  assign rd      = inst[11:7];
  assign rs1     = inst[19:15];
  assign br_imm  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign jal_imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  // Classify the instruction by opcode/funct3
  always_comb begin
    is_br   = 1'b0;
    is_jal  = 1'b0;
    is_jalr = 1'b0;
    case (opcode)
      RV32_OPC_BRANCH: is_br = funct3 inside {RV32_F3_BEQ, RV32_F3_BNE, RV32_F3_BLT,
                                              RV32_F3_BGE, RV32_F3_BLTU, RV32_F3_BGEU};
      RV32_OPC_JAL:    is_jal = 1'b1;
      RV32_OPC_JALR:   is_jalr = (funct3 == RV32_F3_JALR);
      default:         ;
    endcase
  end

  // Build the packet; an invalid lane carries pc/inst but no flags or target
  always_comb begin
    pd      = '0;
    pd.pc   = pc;
    pd.inst = inst;
    if (lane_valid) begin
      pd.valid       = 1'b1;
      pd.cond_branch = is_br;
      pd.jal         = is_jal;
      pd.jalr        = is_jalr;
      pd.is_call     = (is_jal | is_jalr) & is_link_reg(rd);
      pd.is_return   = is_jalr & is_link_reg(rs1) & (rd == 5'd0) & (rs1 != rd);
      if (is_br)
        pd.target = pc + br_imm;
      else if (is_jal)
        pd.target = pc + jal_imm;
      else
        pd.target = '0;
    end
  end

endmodule

// File: rtl/predecode_buffer.sv
// Pre-decodes a WIDTH-lane fetch bundle, marks its oldest control-flow lane and queues it in a FIFO.
module predecode_buffer
  import predecode_buffer_pkg::*;
#(
  parameter int WIDTH       = 2,
  parameter int DEPTH       = 4,
  parameter int TRUNCATE_CF = 1
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 flush,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [WIDTH-1:0]                     in_lane_valid,
  input  logic [WIDTH*32-1:0]                  in_pc,
  input  logic [WIDTH*INST_W-1:0]              in_inst,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [WIDTH*PD_W-1:0]                out_pd,
  output logic                                 out_cf_found,
  output logic [((WIDTH > 1) ? $clog2(WIDTH) : 1)-1:0] out_cf_lane,
  output logic [$clog2(DEPTH):0]               count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int CF_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  predecode_packet_t lane_pd [WIDTH];
  predecode_packet_t enq_pd  [WIDTH];
  logic              cf_found;
  logic              cf_uncond;
  logic [CF_W-1:0]   cf_lane;
  logic              trunc;

  predecode_packet_t mem_pd       [DEPTH][WIDTH];
  logic              mem_cf_found [DEPTH];
  logic [CF_W-1:0]   mem_cf_lane  [DEPTH];

  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic              enq;
  logic              deq;

  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    predecode_buffer_lane u_lane (
      .lane_valid (in_lane_valid[g]),
      .pc         (in_pc[g*32 +: 32]),
      .inst       (in_inst[g*INST_W +: INST_W]),
      .pd         (lane_pd[g])
    );
  end

  // Find the oldest valid control-flow lane and drop younger lanes behind an unconditional jump
  always_comb begin
    cf_found  = 1'b0;
    cf_uncond = 1'b0;
    cf_lane   = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (lane_pd[i].valid && (lane_pd[i].cond_branch || lane_pd[i].jal || lane_pd[i].jalr)) begin
        cf_found  = 1'b1;
        cf_uncond = lane_pd[i].jal || lane_pd[i].jalr;
        cf_lane   = CF_W'(i);
      end
    end
    trunc = (TRUNCATE_CF != 0) && cf_found && cf_uncond;
    for (int i = 0; i < WIDTH; i++) begin
      enq_pd[i] = lane_pd[i];
      if (trunc && (CF_W'(i) > cf_lane))
        enq_pd[i].valid = 1'b0;
    end
  end

  assign in_ready  = (count < DEPTH_C);
  assign out_valid = (count != '0);
  assign enq       = in_valid & in_ready;
  assign deq       = out_valid & out_ready;

  // Bundle storage; contents are never cleared, emptiness is tracked by count alone
  always_ff @(posedge clock) begin
    if (!reset && !flush && enq) begin
      for (int i = 0; i < WIDTH; i++)
        mem_pd[tail][i] <= enq_pd[i];
      mem_cf_found[tail] <= cf_found;
      mem_cf_lane[tail]  <= cf_lane;
    end
  end

  // Pointer and occupancy tracking; reset beats flush, flush beats both handshakes
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq)
        tail <= tail + PTR_W'(1);
      if (deq)
        head <= head + PTR_W'(1);
      case ({enq, deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Present the head entry, forced to zero while the FIFO is empty
  always_comb begin
    out_pd       = '0;
    out_cf_found = 1'b0;
    out_cf_lane  = '0;
    if (out_valid) begin
      for (int i = 0; i < WIDTH; i++)
        out_pd[i*PD_W +: PD_W] = mem_pd[head][i];
      out_cf_found = mem_cf_found[head];
      out_cf_lane  = mem_cf_lane[head];
    end
  end

endmodule
